// File: rtl/conv_pkg.sv
// Shared helpers for the streaming convolution blocks.
// Border sizing, raster counter widths and the border/pass state type.
package conv_pkg;

    typedef enum logic {
        BORDER = 1'b0,
        PASS   = 1'b1
    } pad_state_e;

    function automatic int pad_pre(input int k);
        return (k - 1) / 2;
    endfunction

    function automatic int pad_post(input int k);
        return k - 1 - pad_pre(k);
    endfunction

    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv2d_pad_elastic_reg.sv
// One-entry valid/ready pipeline register.
// Drains and refills in the same cycle, so it sustains one beat per cycle.
module elastic_reg
    import conv_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    assign ready_o = ~valid_q | ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    // Refill whenever the slot is empty or being drained this cycle.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (ready_o) begin
            valid_d = valid_i;
            if (valid_i) begin
                data_d = data_i;
            end
        end
    end

    // Slot state.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/conv2d_pad.sv
// Re-frames a reduced convolution raster into a full frame with pad borders.
// Define CONV2D_PAD_FRAME_FLAGS_EN to add the sof_o/eol_o frame flags.
module conv2d_pad
    import conv_pkg::*;
#(
    parameter int                      LineWidthPx = 160,
    parameter int                      LineCountPx = 120,
    parameter int                      KernelWidth = 3,
    parameter int                      Width       = 32,
    parameter logic signed [Width-1:0] PadValue    = '0
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic signed [Width-1:0] data_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic signed [Width-1:0] data_o
`ifdef CONV2D_PAD_FRAME_FLAGS_EN
    ,
    output logic                    sof_o,
    output logic                    eol_o
`endif
);

    localparam int PRE  = pad_pre(KernelWidth);
    localparam int POST = pad_post(KernelWidth);
    localparam int XW   = cnt_w(LineWidthPx);
    localparam int YW   = cnt_w(LineCountPx);

    localparam logic [XW:0]   X_HI   = (XW + 1)'(LineWidthPx - POST);
    localparam logic [YW:0]   Y_HI   = (YW + 1)'(LineCountPx - POST);
    localparam logic [XW-1:0] X_LAST = XW'(LineWidthPx - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(LineCountPx - 1);

`ifdef CONV2D_PAD_FRAME_FLAGS_EN
    localparam int FW = 2;
`else
    localparam int FW = 0;
`endif
    localparam int PW = Width + FW;

    logic [XW-1:0] ox_q, ox_d;
    logic [YW-1:0] oy_q, oy_d;

    logic       x_lo, y_lo, interior;
    logic       x_last, y_last;
    pad_state_e state;

    logic              load_ok, ld_valid, load;
    logic [Width-1:0]  pix;
    logic [PW-1:0]     pld_in, pld_out;

    if (PRE == 0) begin : g_nopre
        assign x_lo = 1'b1;
        assign y_lo = 1'b1;
    end else begin : g_pre
        localparam logic [XW:0] X_LO = (XW + 1)'(PRE);
        localparam logic [YW:0] Y_LO = (YW + 1)'(PRE);
        assign x_lo = {1'b0, ox_q} >= X_LO;
        assign y_lo = {1'b0, oy_q} >= Y_LO;
    end

    assign interior = x_lo & y_lo
                    & ({1'b0, ox_q} < X_HI)
                    & ({1'b0, oy_q} < Y_HI);
    assign state    = interior ? PASS : BORDER;
    assign x_last   = ox_q == X_LAST;
    assign y_last   = oy_q == Y_LAST;

    // Border pixels are self-generated; interior pixels wait for upstream.
    assign ld_valid = (state == BORDER) | valid_i;
    assign load     = ld_valid & load_ok;
    assign ready_o  = load_ok & (state == PASS);
    assign pix      = (state == PASS) ? data_i : PadValue;

`ifdef CONV2D_PAD_FRAME_FLAGS_EN
    logic first;
    assign first  = (ox_q == '0) & (oy_q == '0);
    assign pld_in = {x_last, first, pix};
    assign sof_o  = pld_out[Width];
    assign eol_o  = pld_out[Width+1];
`else
    assign pld_in = pix;
`endif
    assign data_o = pld_out[Width-1:0];

    elastic_reg #(
        .W (PW)
    ) u_oreg (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .valid_i (ld_valid),
        .ready_o (load_ok),
        .data_i  (pld_in),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (pld_out)
    );

    // Advance the raster position on every output-register load.
    always_comb begin
        ox_d = ox_q;
        oy_d = oy_q;
        if (load) begin
            if (x_last) begin
                ox_d = '0;
                oy_d = y_last ? '0 : oy_q + YW'(1);
            end else begin
                ox_d = ox_q + XW'(1);
            end
        end
    end

    // Raster position registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ox_q <= '0;
            oy_q <= '0;
        end else begin
            ox_q <= ox_d;
            oy_q <= oy_d;
        end
    end

endmodule

// File: tb/tb_conv2d_pad.sv
// Self-checking bench for conv2d_pad (5x4 frames, K=3 pad 0 and K=1 pad -1).
// Frame flags are checked when CONV2D_PAD_FRAME_FLAGS_EN is defined.
module tb_conv2d_pad;

    localparam int LW = 5;
    localparam int LC = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rstn;
    logic                 v_i;
    logic                 r_i;
    logic signed [DW-1:0] d_i;

    logic                 a_ro, a_vo, b_ro, b_vo;
    logic signed [DW-1:0] a_do, b_do;
`ifdef CONV2D_PAD_FRAME_FLAGS_EN
    logic a_sof, a_eol, b_sof, b_eol;
`endif

    conv2d_pad #(
        .LineWidthPx (LW),
        .LineCountPx (LC),
        .KernelWidth (3),
        .Width       (DW),
        .PadValue    (0)
    ) dut_a (
        .clk_i   (clk),
        .rstn_i  (rstn),
        .valid_i (v_i),
        .ready_o (a_ro),
        .data_i  (d_i),
        .valid_o (a_vo),
        .ready_i (r_i),
        .data_o  (a_do)
`ifdef CONV2D_PAD_FRAME_FLAGS_EN
        ,
        .sof_o   (a_sof),
        .eol_o   (a_eol)
`endif
    );

    conv2d_pad #(
        .LineWidthPx (LW),
        .LineCountPx (LC),
        .KernelWidth (1),
        .Width       (DW),
        .PadValue    (-1)
    ) dut_b (
        .clk_i   (clk),
        .rstn_i  (rstn),
        .valid_i (v_i),
        .ready_o (b_ro),
        .data_i  (d_i),
        .valid_o (b_vo),
        .ready_i (r_i),
        .data_o  (b_do)
`ifdef CONV2D_PAD_FRAME_FLAGS_EN
        ,
        .sof_o   (b_sof),
        .eol_o   (b_eol)
`endif
    );

    typedef struct {
        int stim_in;
        int exp_out;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int in_q[$];
    int exp_q[$];

    task automatic chk(input string name, input longint act, input longint req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Expected output stream straight from the framing rule.
    task automatic build_exp(input int k, input int pad, input int nfr);
        int idx = 0;
        int pre = (k - 1) / 2;
        int post = k - 1 - pre;
        exp_q.delete();
        for (int f = 0; f < nfr; f++)
            for (int y = 0; y < LC; y++)
                for (int x = 0; x < LW; x++)
                    if (x >= pre && x < LW - post && y >= pre && y < LC - post) begin
                        exp_q.push_back(in_q[idx]);
                        idx++;
                    end else begin
                        exp_q.push_back(pad);
                    end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        v_i  = 1'b0;
        r_i  = 1'b1;
        d_i  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid_a", a_vo, 0);
        chk("rst_data_a", a_do, 0);
        chk("rst_valid_b", b_vo, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // vmode: 0 always valid, 1 random. rmode: 0 ready, 1 toggle, 2 random.
    task automatic run_stream(input int sel, input int vmode, input int rmode,
                              input int base, input int max_out);
        int idx = 0;
        int nout = 0;
        int cyc = 0;
        logic held = 1'b0;
        logic signed [DW-1:0] hd = '0;
        logic vo, ro, fire;
        logic signed [DW-1:0] dout;
        while (nout < max_out && cyc < 3000) begin
            v_i = (idx < in_q.size()) && (vmode == 0 || $urandom_range(1, 0) == 1);
            d_i = (idx < in_q.size()) ? in_q[idx] : $urandom;
            case (rmode)
                0:       r_i = 1'b1;
                1:       r_i = (cyc % 2) == 0;
                default: r_i = $urandom_range(1, 0) == 1;
            endcase
            @(negedge clk);
            cyc++;
            vo   = sel != 0 ? b_vo : a_vo;
            ro   = sel != 0 ? b_ro : a_ro;
            dout = sel != 0 ? b_do : a_do;
            if (held) begin
                chk("stall_valid", vo, 1);
                chk("stall_data", dout, hd);
            end
            held = vo && !r_i;
            hd   = dout;
            if (vo && r_i) begin
                chk($sformatf("pix[%0d]", base + nout), dout, exp_q[nout]);
`ifdef CONV2D_PAD_FRAME_FLAGS_EN
                chk("sof", sel != 0 ? b_sof : a_sof, ((base + nout) % (LW * LC)) == 0);
                chk("eol", sel != 0 ? b_eol : a_eol, ((base + nout) % LW) == LW - 1);
`endif
                nout++;
            end
            fire = v_i && ro;
            @(posedge clk);
            #1;
            if (fire) idx++;
        end
        if (nout < max_out) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got %0d outputs, expected %0d", nout, max_out);
        end else if (max_out == exp_q.size()) begin
            chk("consumed", idx, in_q.size());
        end
        v_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tab[20];
        int ff_exp[20] = '{0, 0, 0, 0, 0,
                           0, 1, 2, 3, 0,
                           0, 4, 5, 6, 0,
                           0, 0, 0, 0, 0};
        int cnt;

        for (int i = 0; i < 20; i++) begin
            tab[i].stim_in = (i < 6) ? i + 1 : 0;
            tab[i].exp_out = ff_exp[i];
        end

        // Free-flow from the table.
        do_reset();
        in_q.delete();
        exp_q.delete();
        for (int i = 0; i < 20; i++) begin
            if (tab[i].stim_in != 0) in_q.push_back(tab[i].stim_in);
            exp_q.push_back(tab[i].exp_out);
        end
        run_stream(0, 0, 0, 0, 20);

        // Toggled backpressure with random upstream valid.
        do_reset();
        in_q.delete();
        for (int i = 1; i <= 6; i++) in_q.push_back(i);
        build_exp(3, 0, 1);
        run_stream(0, 1, 1, 0, 20);

        // Upstream starvation at the first interior pixel.
        do_reset();
        v_i = 1'b0;
        r_i = 1'b1;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (a_vo) begin
                chk("top_pad", a_do, 0);
                cnt++;
            end
            if (k >= 6) chk("starve_ready", a_ro, 1);
            if (k == 11) chk("starve_valid", a_vo, 0);
            @(posedge clk);
            #1;
        end
        chk("top_count", cnt, 6);
        in_q.delete();
        for (int i = 1; i <= 6; i++) in_q.push_back(i);
        build_exp(3, 0, 1);
        repeat (6) void'(exp_q.pop_front());
        run_stream(0, 0, 0, 6, 14);

        // Three back-to-back frames of random data.
        do_reset();
        in_q.delete();
        for (int i = 0; i < 18; i++) in_q.push_back(int'($urandom));
        build_exp(3, 0, 3);
        run_stream(0, 0, 0, 0, 60);

        // Random valid and ready over two frames.
        do_reset();
        in_q.delete();
        for (int i = 0; i < 12; i++) in_q.push_back(int'($urandom));
        build_exp(3, 0, 2);
        run_stream(0, 1, 2, 0, 40);

        // Asynchronous reset mid-frame, then a clean frame.
        do_reset();
        in_q.delete();
        for (int i = 1; i <= 6; i++) in_q.push_back(i);
        build_exp(3, 0, 1);
        run_stream(0, 0, 0, 0, 9);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_valid", a_vo, 0);
        chk("async_data", a_do, 0);
        v_i = 1'b0;
        r_i = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        in_q.delete();
        for (int i = 0; i < 6; i++) in_q.push_back(100 + i);
        build_exp(3, 0, 1);
        run_stream(0, 0, 0, 0, 20);

        // K=1: single-cycle latency.
        do_reset();
        r_i = 1'b1;
        v_i = 1'b1;
        d_i = 42;
        #1;
        chk("k1_ready", b_ro, 1);
        chk("k1_idle", b_vo, 0);
        @(posedge clk);
        #1;
        v_i = 1'b0;
        chk("k1_lat_valid", b_vo, 1);
        chk("k1_lat_data", b_do, 42);
        @(posedge clk);
        #1;
        chk("k1_drain", b_vo, 0);

        // K=1: pass-through of 0..19, then a random-handshake frame.
        do_reset();
        in_q.delete();
        for (int i = 0; i < 20; i++) in_q.push_back(i);
        build_exp(1, -1, 1);
        run_stream(1, 0, 0, 0, 20);
        in_q.delete();
        for (int i = 0; i < 20; i++) in_q.push_back(int'($urandom));
        build_exp(1, -1, 1);
        run_stream(1, 1, 2, 0, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
